// File: rtl/div_pkg.sv
// Shared constants and types for the multi-cycle divider.
// Holds the state codes, result-ready flags, bus widths and ALU op codes used around it.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Magnitude of a value that is only treated as signed in signed mode.
    function automatic logic [RegBus-1:0] abs_val(input logic is_signed,
                                                  input logic [RegBus-1:0] v);
        return (is_signed && v[RegBus-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Restoring divider (DIV/DIVU): result after 34 edges, or 2 edges for divide by zero.
// Result is held while start_i stays high; annul_i aborts any operation in flight.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e               state_q, state_d;
    logic [5:0]               cnt_q, cnt_d;
    logic [DoubleRegBus:0]    work_q, work_d;
    logic [RegBus-1:0]        divisor_q, divisor_d;
    logic                     sgn_q, sgn_d;
    logic                     neg1_q, neg1_d;
    logic                     neg2_q, neg2_d;
    logic [DoubleRegBus-1:0]  result_q, result_d;
    logic                     ready_q, ready_d;

    logic [RegBus:0]          diff;
    logic [RegBus-1:0]        quot;
    logic [RegBus-1:0]        rem;
    logic                     accept;

    assign accept = start_i && !annul_i;
    assign diff   = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    assign quot   = (sgn_q && (neg1_q ^ neg2_q)) ? (~work_q[31:0] + 1'b1) : work_q[31:0];
    assign rem    = (sgn_q && neg1_q) ? (~work_q[64:33] + 1'b1) : work_q[64:33];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            sgn_q     <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            sgn_q     <= sgn_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DivFree: begin
                if (accept) begin
                    state_d = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: state_d = annul_i ? DivFree : DivEnd;
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (cnt_q == 6'd32) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        sgn_d     = sgn_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        result_d  = result_q;
        ready_d   = ready_q;
        unique case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (accept && (opdata2_i != '0)) begin
                    cnt_d     = '0;
                    work_d    = {32'b0, abs_val(signed_div_i, opdata1_i), 1'b0};
                    divisor_d = abs_val(signed_div_i, opdata2_i);
                    sgn_d     = signed_div_i;
                    neg1_d    = opdata1_i[RegBus-1];
                    neg2_d    = opdata2_i[RegBus-1];
                end
            end
            DivByZero: begin
                result_d = '0;
                ready_d  = annul_i ? DivResultNotReady : DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else if (cnt_q != 6'd32) begin
                    // A borrow out of bit 32 means the divisor does not fit: shift in 0.
                    work_d = diff[RegBus] ? {work_q[63:0], 1'b0}
                                          : {diff[31:0], work_q[31:0], 1'b1};
                    cnt_d  = cnt_q + 6'd1;
                end else begin
                    cnt_d    = '0;
                    result_d = {rem, quot};
                    ready_d  = DivResultReady;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed checks of the divider: results, exact latency, hold, annul and reset behaviour.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_errors = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Operands are scrambled after the capture edge; drop releases start_i mid-operation.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int exp_lat, input bit drop);
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        while (!got && n < 60) begin
            tick();
            n++;
            if (n == 1) begin
                opdata1_i    = ~a;
                opdata2_i    = b + 32'd5;
                signed_div_i = ~sgn;
                if (drop) start_i = 1'b0;
            end
            if (ready_o) got = 1'b1;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " result"}, result_o, exp);
        if (!drop) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                chk({tag, " hold ready"}, 64'(ready_o), 64'd1);
                chk({tag, " hold result"}, result_o, exp);
            end
            start_i = 1'b0;
        end
        tick();
        chk({tag, " release ready"}, 64'(ready_o), 64'd0);
        chk({tag, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        bit seen;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd10;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        repeat (3) tick();
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        start_i = 1'b0;
        rst     = 1'b0;
        tick();
        chk("idle ready", 64'(ready_o), 64'd0);

        run_div("divu ffffffff/2", 1'b0, 32'hFFFF_FFFF, 32'd2, {32'h1, 32'h7FFF_FFFF}, 34, 1'b0);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 1'b0);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34, 1'b1);
        run_div("div -8/-3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'h2}, 34, 1'b0);
        run_div("divu 80000000/ffffffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'h8000_0000, 32'h0}, 34, 1'b0);
        run_div("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'h0, 32'h8000_0000}, 34, 1'b0);
        run_div("div by zero", 1'b0, 32'd100, 32'd0, 64'd0, 2, 1'b0);

        // start_i and annul_i together in DivFree must not launch anything.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        seen         = 1'b0;
        repeat (40) begin
            tick();
            seen |= ready_o;
        end
        chk("start+annul idle", 64'(seen), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();

        // Annul at iteration 10 of 5/3.
        opdata1_i = 32'd5;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        tick();
        repeat (10) tick();
        annul_i = 1'b1;
        tick();
        chk("annul ready", 64'(ready_o), 64'd0);
        chk("annul result", result_o, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen    = 1'b0;
        repeat (40) begin
            tick();
            seen |= ready_o;
        end
        chk("annul no result", 64'(seen), 64'd0);
        run_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34, 1'b0);

        // Annul while in DivByZero.
        opdata1_i = 32'd1;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        tick();
        annul_i = 1'b1;
        tick();
        chk("annul by-zero ready", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        tick();
        chk("annul by-zero idle", 64'(ready_o), 64'd0);

        // Reset at iteration 20, with start_i still high to exercise reset priority.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        tick();
        repeat (20) tick();
        rst = 1'b1;
        tick();
        chk("mid reset ready", 64'(ready_o), 64'd0);
        chk("mid reset result", result_o, 64'd0);
        rst = 1'b0;
        run_div("divu 100/7 after reset", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from the shared defines (RegBus = 32 bits, DoubleRegBus = 64 bits).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high (RstEnable = 1'b1).
- signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned divide (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  divide request; the EX stage holds it high until it has consumed the result.
- annul_i  in  1  abort the operation in flight (pipeline flush).
- result_o  out  64  {remainder, quotient}; bits [63:32] are written to HI and bits [31:0] to LO.
- ready_o  out  1  result_o valid (DivResultReady).

Function
REQ-004 The block SHALL be an FSM with four states from the shared defines: DivFree, DivByZero, DivOn, DivEnd.
REQ-005 DivFree transitions:
- start_i = 1 and annul_i = 0 and opdata2_i = 0: go to DivByZero.
- start_i = 1 and annul_i = 0 and opdata2_i != 0: go to DivOn with cnt = 0.
- Otherwise: stay in DivFree, with ready_o = 0 and result_o = 0.
REQ-006 Operand capture on DivFree -> DivOn:
- In signed mode, a negative operand SHALL be replaced by its two's complement (absolute value, treated as unsigned).
- The 65-bit work register SHALL be loaded with {32'b0, |dividend|, 1'b0}.
- |divisor| SHALL be latched together with signed_div_i and both original operand sign bits.
REQ-007 Each DivOn cycle with cnt < 32 SHALL perform one restoring step:
- diff = work[63:32] - divisor, computed at 33 bits.
- diff negative: work <= {work[63:0], 1'b0}.
- diff not negative: work <= {diff[31:0], work[31:0], 1'b1}.
- cnt increments by 1.
REQ-008 In DivOn with cnt = 32, the block SHALL finish as follows:
- Quotient = work[31:0]; remainder = work[64:33].
- In signed mode, the quotient SHALL be negated when the operand signs differ.
- In signed mode, the remainder SHALL be negated when the dividend is negative.
- result_o <= {remainder, quotient}; ready_o <= 1; go to DivEnd.
REQ-009 DivByZero SHALL load result_o <= 64'h0 and ready_o <= 1, then go to DivEnd.
REQ-010 DivEnd SHALL hold result_o and ready_o stable while start_i = 1. When start_i = 0 it SHALL go to DivFree with ready_o <= 0 and result_o <= 0.
REQ-011 Latency SHALL be exact:
- Normal divide: ready_o rises on the 34th rising edge after the edge that sampled start_i in DivFree.
- Divide by zero: ready_o rises on the 2nd rising edge.
REQ-012 annul_i = 1 in DivOn or DivByZero SHALL return the block to DivFree on the next edge with ready_o = 0 and result_o = 0. No result SHALL be produced.
REQ-013 start_i and annul_i both high in DivFree SHALL leave the block in DivFree.
REQ-014 Deassertion of start_i during DivOn without annul_i SHALL be ignored; the operation completes.
REQ-015 Operand changes after capture SHALL NOT affect the result in flight.
REQ-016 Arithmetic SHALL wrap modulo 2^32: signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-017 ready_o and result_o SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-018 rst = 1 at a clock edge SHALL force the following, from any state including mid-operation:
- state = DivFree.
- cnt = 0, work = 0.
- ready_o = 0 (DivResultNotReady).
- result_o = 64'h0.
REQ-019 rst SHALL take priority over start_i and annul_i.

Structure
REQ-020 The shared defines SHALL hold these constants; no local redefinition is allowed:
- State codes DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
- DivResultReady / DivResultNotReady.
- DivStart / DivStop.
- RegBus, DoubleRegBus.
- The new ALU ops EXE_DIV_OP and EXE_DIVU_OP.
REQ-021 The block SHALL be a single module containing one sequential FSM/datapath process; no sub-module is required.
REQ-022 The EX stage SHALL drive start_i, annul_i and the operands, and SHALL raise stallreq while DIV/DIVU is in flight with ready_o = 0.

Verification
REQ-023 Unsigned divide: signed_div_i = 0, 0xFFFFFFFF / 2 -> ready_o on edge 34, result_o = {32'h1, 32'h7FFFFFFF}.
REQ-024 Signed divide: signed_div_i = 1, -7 / 2 (0xFFFFFFF9 / 2) -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}, i.e. quotient -3, remainder -1.
REQ-025 Divide by zero: 100 / 0 -> ready_o on edge 2, result_o = 64'h0; start_i dropped -> ready_o = 0 on the next edge.
REQ-026 Annul: annul_i pulsed at iteration 10 of 5 / 3 -> DivFree, ready_o never asserted; a new 9 / 3 then returns {0, 3} at edge 34.
REQ-027 Reset mid-operation: rst asserted at iteration 20 -> ready_o = 0 and result_o = 0 on the next edge; the block then accepts a new start_i.
REQ-028 Signed overflow corner: 0x80000000 / 0xFFFFFFFF, signed -> result_o = {32'h0, 32'h80000000}; result_o is held stable in DivEnd while start_i = 1.
